lut_layer_pipe: RTL and testbench
=================================

# lut_layer_pipe

Parametrised, pipelined layer of N truth-table neurons. Each neuron maps a FAN_IN-bit input slice to an OUT_BITS-bit code through a runtime-loadable table held in flops. A valid/ready handshake and optional output register let the layer be chained between other layer stages, replacing per-neuron fixed combinational LUT modules in generated network top levels.

## Interface
Parameters:
- N, 4: neurons in the layer.
- FAN_IN, 8: input bits per neuron; table depth is 2^FAN_IN.
- OUT_BITS, 1: output code width per neuron.
- CNT_W, 16: width of the lookup counter.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst_n  in  1  Asynchronous active-low reset.
- in_valid  in  1  Input vector valid.
- in_ready  out  1  Layer can accept an input this cycle.
- in_data  in  N*FAN_IN  Neuron k reads bits [k*FAN_IN +: FAN_IN]; bit 0 of the slice is address LSB.
- out_valid  out  1  Output vector valid.
- out_ready  in  1  Downstream accepts the output.
- out_data  out  N*OUT_BITS  Neuron k drives [k*OUT_BITS +: OUT_BITS].
- cfg_we  in  1  Table write strobe.
- cfg_neuron  in  $clog2(N) (min 1)  Target neuron.
- cfg_addr  in  FAN_IN  Target table entry.
- cfg_data  in  OUT_BITS  Entry value.
- lookup_cnt  out  CNT_W  Count of accepted input vectors.

## Operation
- Tables: N x 2^FAN_IN x OUT_BITS flops; all entries cleared to 0 on reset.
- Config write: when cfg_we=1, entry [cfg_neuron][cfg_addr] takes cfg_data at the clock edge. Writes are accepted every cycle, independent of the handshake. A cfg_neuron value >= N is ignored with no effect.
- Same-cycle hazard: a lookup accepted in the same cycle as a write to the same entry uses the pre-write value.
- Input transfer: occurs when in_valid && in_ready. All N neurons look up their slices in parallel, and the results are captured into stage 1.
- Stage 1 holds s1_valid and s1_data. When out_ready=0 with valid data held, the held data and valid remain stable.
- in_ready = !s_last_valid || out_ready, where s_last is the final stage. This is combinational from out_ready; no other combinational in-to-out path exists.
- lookup_cnt increments by 1 on each input transfer and wraps modulo 2^CNT_W.
- Reset mid-operation: all valids drop to 0 and lookup_cnt returns to 0 immediately; in-flight data is discarded.

## Timing
- Reset values: out_valid=0, out_data=0, lookup_cnt=0, all tables 0. in_ready=1 after reset.
- Latency: 1 cycle from input transfer to out_valid. It is 2 cycles with LUT_OUT_REG_EN.
- Throughput: one vector per cycle while out_ready=1.
- out_data changes only on a cycle where the final stage is loaded.
- A table write at edge T is visible to lookups accepted at edge T+1 or later.

## Configuration
- LUT_OUT_REG_EN:
  - Defined: a second register stage (s2_valid, s2_data) follows stage 1 and is the final stage. Stage 1 advances when !s2_valid || out_ready, and in_ready = !s1_valid || (!s2_valid || out_ready). This keeps full throughput with 2-cycle latency.
  - Undefined: stage 1 is the final stage, with 1-cycle latency.

## Structure
- Package lut_layer_pkg holds:
  - the CNT_W default;
  - the localparam function for table depth (1 << FAN_IN);
  - a typedef for the config write bundle (we, neuron, addr, data).
- Sub-module lut_neuron_tbl: one neuron's table with its write port and combinational read. It is instantiated N times by a generate loop in lut_layer_pipe, which owns the pipeline registers and the counter.

## Test plan
- Reset then idle: out_valid=0, out_data=0, lookup_cnt=0, in_ready=1.
- Load identity-parity table (N=4, FAN_IN=8, OUT_BITS=1, entry = ^addr) for all neurons, then drive in_data=32'h01_03_07_FF with out_ready=1. One cycle later, out_data=4'b1010 (neuron 0..3: slice 8'hFF→0, 8'h07→1, 8'h03→0, 8'h01→1) and out_valid=1.
- Backpressure: stream 3 vectors and hold out_ready=0 for 4 cycles. out_data and out_valid stay stable, in_ready=0, and no vector is lost or duplicated on release; lookup_cnt=3.
- Write/lookup collision:
  - Setup: entry [2][8'h05]=1.
  - Same cycle: write 0 to that entry and transfer a vector whose neuron 2 slice is 8'h05. Output bit 2 = 1.
  - Repeat the vector next cycle: bit 2 = 0.
- Counter wrap with CNT_W=4: 17 transfers give lookup_cnt=1.
- Assert rst_n low while out_valid=1 and out_ready=0. Outputs return to reset values asynchronously, and tables read 0 afterwards.

Source files
------------

// File: rtl/lut_layer_pkg.sv
// Shared types and constants for the LUT neuron layer: counter width default,
// table depth helper and the config write bundle carried to every neuron table.
package lut_layer_pkg;

    localparam int CNT_W_DEF    = 16;
    localparam int CFG_NEURON_W = 8;
    localparam int CFG_ADDR_W   = 16;
    localparam int CFG_DATA_W   = 16;

    function automatic int tbl_depth(input int fan_in);
        return 1 << fan_in;
    endfunction

    // Fields are sized for the largest supported layer; the top zero-extends.
    typedef struct packed {
        logic                    we;
        logic [CFG_NEURON_W-1:0] neuron;
        logic [CFG_ADDR_W-1:0]   addr;
        logic [CFG_DATA_W-1:0]   data;
    } cfg_wr_t;

endpackage

// File: rtl/lut_neuron_tbl.sv
// One truth-table neuron: a flop-based table with a single write port and a
// combinational read, so a same-edge write never affects the current lookup.
module lut_neuron_tbl
    import lut_layer_pkg::*;
#(
    parameter int FAN_IN   = 8,
    parameter int OUT_BITS = 1,
    parameter int IDX      = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  cfg_wr_t             cfg,
    input  logic [FAN_IN-1:0]   addr,
    output logic [OUT_BITS-1:0] rdata
);

    localparam int DEPTH = tbl_depth(FAN_IN);

    logic [DEPTH-1:0][OUT_BITS-1:0] tbl;
    logic                           wr_hit;
    logic [FAN_IN-1:0]              wa;

    // Neuron ids beyond the layer never match any IDX, so they fall through.
    assign wr_hit = cfg.we && (cfg.neuron == CFG_NEURON_W'(IDX));
    assign wa     = FAN_IN'(cfg.addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tbl <= '0;
        else if (wr_hit)
            tbl[wa] <= OUT_BITS'(cfg.data);
    end

    assign rdata = tbl[addr];

endmodule

// File: rtl/lut_layer_pipe.sv
// Pipelined layer of N truth-table neurons with valid/ready handshake.
// Define LUT_OUT_REG_EN to add a second output register stage (2-cycle latency).
module lut_layer_pipe
    import lut_layer_pkg::*;
#(
    parameter int N        = 4,
    parameter int FAN_IN   = 8,
    parameter int OUT_BITS = 1,
    parameter int CNT_W    = CNT_W_DEF,
    localparam int NW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*FAN_IN-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*OUT_BITS-1:0] out_data,
    input  logic                  cfg_we,
    input  logic [NW-1:0]         cfg_neuron,
    input  logic [FAN_IN-1:0]     cfg_addr,
    input  logic [OUT_BITS-1:0]   cfg_data,
    output logic [CNT_W-1:0]      lookup_cnt
);

`ifdef LUT_OUT_REG_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    cfg_wr_t                    cfg;
    logic [N-1:0][OUT_BITS-1:0] lut_q;
    logic [N-1:0][OUT_BITS-1:0] s1_data;
    logic [STAGES:1]            vld_q;
    logic [STAGES:0]            vld_pipe;
    logic                       xfer;
    logic                       s1_adv;
    logic [CNT_W-1:0]           cnt;

    always_comb begin
        cfg                    = '0;
        cfg.we                 = cfg_we;
        cfg.neuron[NW-1:0]     = cfg_neuron;
        cfg.addr[FAN_IN-1:0]   = cfg_addr;
        cfg.data[OUT_BITS-1:0] = cfg_data;
    end

    for (genvar k = 0; k < N; k++) begin : g_nrn
        lut_neuron_tbl #(
            .FAN_IN   (FAN_IN),
            .OUT_BITS (OUT_BITS),
            .IDX      (k)
        ) u_tbl (
            .clk   (clk),
            .rst_n (rst_n),
            .cfg   (cfg),
            .addr  (in_data[k*FAN_IN +: FAN_IN]),
            .rdata (lut_q[k])
        );
    end

    // Bit 0 is the transfer into stage 1; bit STAGES is the output stage.
    assign vld_pipe = {vld_q, xfer};

`ifdef LUT_OUT_REG_EN
    logic                       s2_adv;
    logic [N-1:0][OUT_BITS-1:0] s2_data;

    assign s2_adv = !vld_pipe[2] || out_ready;
    assign s1_adv = !vld_pipe[1] || s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q[2] <= 1'b0;
            s2_data  <= '0;
        end else if (s2_adv) begin
            vld_q[2] <= vld_pipe[1];
            if (vld_pipe[1])
                s2_data <= s1_data;
        end
    end

    assign out_data = s2_data;
`else
    assign s1_adv   = !vld_pipe[1] || out_ready;
    assign out_data = s1_data;
`endif

    assign in_ready  = s1_adv;
    assign xfer      = in_valid && in_ready;
    assign out_valid = vld_pipe[STAGES];

    // Data loads only on a transfer so a drained stage keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q[1] <= 1'b0;
            s1_data  <= '0;
        end else if (s1_adv) begin
            vld_q[1] <= vld_pipe[0];
            if (vld_pipe[0])
                s1_data <= lut_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (xfer)
            cnt <= cnt + 1'b1;
    end

    assign lookup_cnt = cnt;

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Randomised and directed bench for lut_layer_pipe against a table/queue reference model.
module tb_lut_layer_pipe;

    localparam int N  = 4;
    localparam int FI = 8;
    localparam int OB = 1;
    localparam int CW = 4;
`ifdef LUT_OUT_REG_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N*FI-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N*OB-1:0] out_data;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_neuron = '0;
    logic [FI-1:0] cfg_addr = '0;
    logic [OB-1:0] cfg_data = '0;
    logic [CW-1:0] lookup_cnt;

    int n_cmp = 0;
    int n_err = 0;

    bit             mdl [N][256];
    int             mdl_cnt = 0;
    logic [N-1:0]   q[$];
    logic [N-1:0]   got[$];

    always #5 clk = ~clk;

    lut_layer_pipe #(.N(N), .FAN_IN(FI), .OUT_BITS(OB), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .lookup_cnt (lookup_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_out(input logic [N*FI-1:0] v);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++)
            r[k] = mdl[k][int'((v >> (k*FI)) & 32'hFF)];
        return r;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < N; k++)
            for (int a = 0; a < 256; a++)
                mdl[k][a] = 1'b0;
        q.delete();
        mdl_cnt = 0;
    endtask

    // One cycle: check outputs against the model, then advance the model and clock.
    task automatic tick(output bit acc);
        #1;
        acc = in_valid && in_ready;
        chk("in_ready", in_ready, (q.size() < STAGES) || out_ready);
        chk("lookup_cnt", lookup_cnt, mdl_cnt);
        if (q.size() == 0 || q.size() >= STAGES)
            chk("out_valid", out_valid, q.size() != 0);
        if (out_valid) begin
            if (q.size() == 0)
                chk("spurious_out", out_valid, 0);
            else begin
                chk("out_data", out_data, q[0]);
                if (out_ready) begin
                    got.push_back(out_data);
                    void'(q.pop_front());
                end
            end
        end
        if (acc) begin
            q.push_back(ref_out(in_data));
            mdl_cnt = (mdl_cnt + 1) % (1 << CW);
        end
        if (cfg_we && int'(cfg_neuron) < N)
            mdl[cfg_neuron][cfg_addr] = cfg_data[0];
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick(acc);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        bit acc;
        int base, idx;
        logic [N*FI-1:0] bpv [3];
        logic [N*FI-1:0] cv;

        clear_model();
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cnt", lookup_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick(acc);

        // Parity tables in every neuron.
        for (int n = 0; n < N; n++) begin
            for (int a = 0; a < 256; a++) begin
                cfg_we     = 1'b1;
                cfg_neuron = 2'(n);
                cfg_addr   = 8'(a);
                cfg_data   = ^cfg_addr;
                tick(acc);
            end
        end
        cfg_we = 1'b0;

        got.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h01_03_07_FF;
        tick(acc);
        chk("par_acc", acc, 1);
        in_valid = 1'b0;
        repeat (STAGES - 1) tick(acc);
        #1;
        chk("par_lat_vld", out_valid, 1);
        chk("par_lat_dat", out_data, 4'b1010);
        drain();
        chk("par_n", got.size(), 1);
        if (got.size() >= 1) chk("par_val", got[0], 4'b1010);

        // Backpressure: 4 stalled cycles in the middle of a 3-vector stream.
        got.delete();
        base = mdl_cnt;
        idx  = 0;
        for (int i = 0; i < 3; i++) bpv[i] = $urandom;
        for (int c = 0; c < 40 && (idx < 3 || q.size() != 0); c++) begin
            out_ready = !(c >= 1 && c <= 4);
            in_valid  = (idx < 3);
            in_data   = bpv[idx % 3];
            if (c == 4) begin
                #1;
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
            end
            tick(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        drain();
        chk("bp_n", got.size(), 3);
        if (got.size() == 3)
            for (int i = 0; i < 3; i++)
                chk("bp_order", got[i], ref_out(bpv[i]));
        chk("bp_cnt", lookup_cnt, (base + 3) % (1 << CW));

        // Write/lookup collision on neuron 2, entry 8'h05.
        cfg_we = 1'b1; cfg_neuron = 2'd2; cfg_addr = 8'h05; cfg_data = 1'b1;
        tick(acc);
        cfg_we = 1'b0;
        got.delete();
        cv = $urandom;
        cv[2*FI +: FI] = 8'h05;
        in_valid = 1'b1; in_data = cv;
        cfg_we = 1'b1; cfg_data = 1'b0;
        tick(acc);
        chk("coll_acc0", acc, 1);
        cfg_we = 1'b0;
        tick(acc);
        chk("coll_acc1", acc, 1);
        drain();
        chk("coll_n", got.size(), 2);
        if (got.size() == 2) begin
            chk("coll_pre", got[0][2], 1);
            chk("coll_post", got[1][2], 0);
        end

        // Random traffic with random config writes, many aimed at live slices.
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom % 4) != 0;
            in_data    = $urandom;
            out_ready  = ($urandom % 3) != 0;
            cfg_we     = ($urandom % 4) == 0;
            cfg_neuron = 2'($urandom % 4);
            cfg_addr   = ($urandom % 2) ? in_data[cfg_neuron*FI +: FI] : 8'($urandom);
            cfg_data   = 1'($urandom);
            tick(acc);
        end
        drain();

        // Asynchronous reset while the output is stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        tick(acc);
        tick(acc);
        in_valid = 1'b0;
        #1;
        chk("prerst_vld", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #2;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_cnt", lookup_cnt, 0);
        chk("arst_in_ready", in_ready, 1);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap; tables must all read zero after reset.
        got.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = $urandom;
            tick(acc);
        end
        in_valid = 1'b0;
        #1;
        chk("wrap_cnt", lookup_cnt, 1);
        drain();
        chk("zero_n", got.size(), 17);
        foreach (got[i]) chk("zero_tbl", got[i], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
